// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder datapath.
// Contents:
//   ser_state_t - serializer FSM state encoding
//   cnt_width() - bit-index counter width for a frame of width+flush_bits
//                 bits; the downstream sum collector uses the same helper.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } ser_state_t;

    // Wide enough to hold every bit index 0..width+flush_bits-1.
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned flush_bits);
        return $clog2(width + flush_bits + 1);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first, zero fill.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   load     - capture d (has priority over shift)
//   shift    - shift right by one, zero into the MSB
//   d        - parallel load data
//   q_lsb    - current LSB, taken straight from the register
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_lsb
);

    logic [WIDTH-1:0] r_sreg;

    // Zero fill means the register drains to 0 once all bits have left,
    // so q_lsb is naturally 0 during flush and idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (load) begin
            r_sreg <= d;
        end else if (shift) begin
            r_sreg <= r_sreg >> 1;
        end
    end

    assign q_lsb = r_sreg[0];

endmodule

// File: rtl/operand_serializer.sv
// Operand serializer feeding a bit-serial adder.
// Accepts an operand pair over valid/ready and streams it LSB first, one
// bit pair per clock, followed by FLUSH_BITS zero pairs so the adder's
// final carry is emitted and cleared before the next frame.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operand handshake (in_ready is combinational)
//   a_in, b_in          - parallel operands
//   out_seq1, out_seq2  - serial bits of A and B (0 during flush/idle)
//   bit_valid           - a frame bit is on out_seq1/out_seq2
//   first_bit, last_bit - frame markers for the downstream collector
//   busy                - a frame is in progress
module operand_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FLUSH_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_seq1,
    output logic             out_seq2,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned CW        = cnt_width(WIDTH, FLUSH_BITS);
    localparam int unsigned FRAME_LEN = WIDTH + FLUSH_BITS;
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] WIDTH_IDX = CW'(WIDTH);

    ser_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_bit_valid;
    logic          r_first_bit;
    logic          r_last_bit;
    logic          r_busy;

    logic          w_accept;
    logic [CW-1:0] w_next_cnt;
    logic          w_a_lsb;
    logic          w_b_lsb;

    // A new pair may enter while idle or while the final frame bit is out.
    assign in_ready   = (r_state == IDLE) || r_last_bit;
    assign w_accept   = in_valid && in_ready;
    assign w_next_cnt = r_cnt + CW'(1);

    // The shift registers hold the bit currently on the outputs, so the
    // operand LSB appears in the cycle right after the accept edge.
    piso_shift_reg #(.WIDTH(WIDTH)) u_sreg_a (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (r_busy),
        .d     (a_in),
        .q_lsb (w_a_lsb)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sreg_b (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (r_busy),
        .d     (b_in),
        .q_lsb (w_b_lsb)
    );

    // FSM: r_state/r_cnt describe the bit currently presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_valid <= 1'b0;
            r_first_bit <= 1'b0;
            r_last_bit  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_state     <= SHIFT;
            r_cnt       <= '0;
            r_bit_valid <= 1'b1;
            r_first_bit <= 1'b1;
            r_last_bit  <= (LAST_IDX == CW'(0));
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt       <= '0;
                    r_bit_valid <= 1'b0;
                    r_first_bit <= 1'b0;
                    r_last_bit  <= 1'b0;
                    r_busy      <= 1'b0;
                end
                SHIFT, FLUSH: begin
                    r_first_bit <= 1'b0;
                    if (r_last_bit) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_bit_valid <= 1'b0;
                        r_last_bit  <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt      <= w_next_cnt;
                        r_state    <= (w_next_cnt < WIDTH_IDX) ? SHIFT : FLUSH;
                        r_last_bit <= (w_next_cnt == LAST_IDX);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_bit_valid <= 1'b0;
                    r_first_bit <= 1'b0;
                    r_last_bit  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_seq1  = w_a_lsb;
    assign out_seq2  = w_b_lsb;
    assign bit_valid = r_bit_valid;
    assign first_bit = r_first_bit;
    assign last_bit  = r_last_bit;
    assign busy      = r_busy;

endmodule

// File: tb/tb_operand_serializer.sv
// Self-checking bench for operand_serializer: one instance with WIDTH=8,
// FLUSH_BITS=1 and one with WIDTH=4, FLUSH_BITS=0. Expected bit streams and
// sums are queued at each accept and compared as the frame comes out; a
// small serial-adder model turns the observed streams into sums.
module tb_operand_serializer;

    localparam int unsigned W0 = 8;
    localparam int unsigned F0 = 1;
    localparam int unsigned W1 = 4;
    localparam int unsigned F1 = 0;

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] iv;
    logic [7:0] av [2];
    logic [7:0] bv [2];

    wire  [1:0] rdy, s1, s2, bvd, fb, lb, by;

    always #5 clk = ~clk;

    operand_serializer #(.WIDTH(W0), .FLUSH_BITS(F0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[0]),
        .in_ready  (rdy[0]),
        .a_in      (av[0]),
        .b_in      (bv[0]),
        .out_seq1  (s1[0]),
        .out_seq2  (s2[0]),
        .bit_valid (bvd[0]),
        .first_bit (fb[0]),
        .last_bit  (lb[0]),
        .busy      (by[0])
    );

    operand_serializer #(.WIDTH(W1), .FLUSH_BITS(F1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[1]),
        .in_ready  (rdy[1]),
        .a_in      (av[1][3:0]),
        .b_in      (bv[1][3:0]),
        .out_seq1  (s1[1]),
        .out_seq2  (s2[1]),
        .bit_valid (bvd[1]),
        .first_bit (fb[1]),
        .last_bit  (lb[1]),
        .busy      (by[1])
    );

    // Scoreboard and adder-model state, one slot per instance.
    item_t       q0 [$];
    item_t       q1 [$];
    logic [15:0] sq0 [$];
    logic [15:0] sq1 [$];
    item_t       cur   [2];
    logic        act   [2];
    logic        carry [2];
    logic [15:0] acc   [2];
    int          idx   [2];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int unsigned wd(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic int unsigned fd(input int d);
        return (d == 0) ? F0 : F1;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the full expected frame and sum for the pair on av[d]/bv[d].
    task automatic push_frame(input int d);
        int unsigned n;
        logic [15:0] opmask;
        logic [15:0] summask;
        logic [15:0] sum;
        item_t       it;
        n       = wd(d) + fd(d);
        opmask  = 16'((32'd1 << wd(d)) - 32'd1);
        summask = 16'((32'd1 << n) - 32'd1);
        for (int i = 0; i < int'(n); i++) begin
            it.a     = (i < int'(wd(d))) ? av[d][i] : 1'b0;
            it.b     = (i < int'(wd(d))) ? bv[d][i] : 1'b0;
            it.first = (i == 0);
            it.last  = (i == int'(n) - 1);
            if (d == 0) q0.push_back(it);
            else        q1.push_back(it);
        end
        sum = ((16'(av[d]) & opmask) + (16'(bv[d]) & opmask)) & summask;
        if (d == 0) sq0.push_back(sum);
        else        sq1.push_back(sum);
    endtask

    // One clock: check in_ready and queue accepts before the edge, then
    // check every output 1 time unit after it.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            logic er;
            er = !act[d] || cur[d].last;
            if (!rst) begin
                check($sformatf("in_ready[%0d]", d), 16'(rdy[d]), 16'(er));
                if (iv[d] && er) push_frame(d);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            item_t       e;
            logic        sb;
            logic [15:0] exp_sum;
            if (rst) begin
                if (d == 0) begin q0.delete(); sq0.delete(); end
                else        begin q1.delete(); sq1.delete(); end
                act[d]   = 1'b0;
                carry[d] = 1'b0;
            end else if (d == 0 && q0.size() > 0) begin
                cur[d] = q0.pop_front();
                act[d] = 1'b1;
            end else if (d == 1 && q1.size() > 0) begin
                cur[d] = q1.pop_front();
                act[d] = 1'b1;
            end else begin
                act[d] = 1'b0;
            end
            e = act[d] ? cur[d] : '0;
            check($sformatf("out_seq1[%0d]", d),  16'(s1[d]),  16'(e.a));
            check($sformatf("out_seq2[%0d]", d),  16'(s2[d]),  16'(e.b));
            check($sformatf("bit_valid[%0d]", d), 16'(bvd[d]), 16'(act[d]));
            check($sformatf("first_bit[%0d]", d), 16'(fb[d]),  16'(e.first));
            check($sformatf("last_bit[%0d]", d),  16'(lb[d]),  16'(e.last));
            check($sformatf("busy[%0d]", d),      16'(by[d]),  16'(act[d]));
            if (act[d]) begin
                if (e.first) begin
                    carry[d] = 1'b0;
                    acc[d]   = '0;
                    idx[d]   = 0;
                end
                sb       = s1[d] ^ s2[d] ^ carry[d];
                carry[d] = (s1[d] & s2[d]) | (carry[d] & (s1[d] ^ s2[d]));
                acc[d][idx[d]] = sb;
                idx[d]++;
                if (e.last) begin
                    exp_sum = (d == 0) ? sq0.pop_front() : sq1.pop_front();
                    check($sformatf("adder_sum[%0d]", d), acc[d], exp_sum);
                    if (fd(d) > 0)
                        check($sformatf("adder_carry_clear[%0d]", d), 16'(carry[d]), 16'(0));
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cur[d]   = '0;
            act[d]   = 1'b0;
            carry[d] = 1'b0;
            acc[d]   = '0;
            idx[d]   = 0;
            av[d]    = '0;
            bv[d]    = '0;
        end
        rst = 1'b1;
        iv  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Single frame 0x35 + 0x5A -> 0x08F.
        av[0] = 8'h35; bv[0] = 8'h5A; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (10) tick();

        // 0xFF + 0x01 -> 0x100, carry emitted in the flush bit.
        av[0] = 8'hFF; bv[0] = 8'h01; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (10) tick();

        // Back-to-back with in_valid held: 0x0F+0x01 then 0x80+0x80.
        av[0] = 8'h0F; bv[0] = 8'h01; iv[0] = 1'b1;
        tick();
        av[0] = 8'h80; bv[0] = 8'h80;
        repeat (9) tick();
        iv[0] = 1'b0;
        repeat (10) tick();

        // Operand changes with in_valid high mid-frame are ignored.
        av[0] = 8'hA5; bv[0] = 8'h3C; iv[0] = 1'b1;
        tick();
        repeat (7) begin
            av[0] = 8'($urandom);
            bv[0] = 8'($urandom);
            tick();
        end
        iv[0] = 1'b0;
        repeat (3) tick();

        // Reset mid-frame (with in_valid high), then a fresh frame.
        av[0] = 8'h77; bv[0] = 8'h11; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1; iv[0] = 1'b1; av[0] = 8'hC3; bv[0] = 8'h3C;
        tick();
        rst = 1'b0; iv[0] = 1'b0;
        tick();
        av[0] = 8'h12; bv[0] = 8'h34; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (10) tick();

        // No flush, WIDTH=4: 0x9 + 0x3, last_bit on the MSB.
        av[1] = 8'h09; bv[1] = 8'h03; iv[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        repeat (5) tick();

        // No flush, back-to-back: 0x5+0x6 then 0x2+0x7.
        av[1] = 8'h05; bv[1] = 8'h06; iv[1] = 1'b1;
        tick();
        av[1] = 8'h02; bv[1] = 8'h07;
        repeat (4) tick();
        iv[1] = 1'b0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_serializer.md
# operand_serializer

Upstream feeder for the bit-serial adder. Accepts two WIDTH-bit operands in parallel through a valid/ready handshake and streams them LSB-first, one bit pair per clock, onto the adder's two serial inputs. After the MSB it appends FLUSH_BITS cycles of zero pairs so the final carry reaches the adder output and the adder's carry is clear before the next frame. Frame-marker outputs let a downstream collector align the serial sum.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be at least 1.
- FLUSH_BITS, 1, number of zero-pair cycles appended after the MSB; must be at least 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on a_in/b_in is valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- a_in  input  WIDTH  operand A; drives the adder's in_seq1.
- b_in  input  WIDTH  operand B; drives the adder's in_seq2.
- out_seq1  output  1  serial bit of A, LSB first; zero during flush.
- out_seq2  output  1  serial bit of B, LSB first; zero during flush.
- bit_valid  output  1  out_seq1/out_seq2 carry a frame bit this cycle.
- first_bit  output  1  current bit is bit 0 of a frame.
- last_bit  output  1  current bit is the final bit of a frame: the last flush bit, or the MSB if FLUSH_BITS=0.
- busy  output  1  a frame is in progress.

## Operation
- States: IDLE, SHIFT, FLUSH.
- IDLE: bit_valid=0, out_seq1=out_seq2=0, in_ready=1.
- Accept: in_valid && in_ready at a rising edge.
  - Loads a_in and b_in into two shift registers.
  - Clears the bit counter.
  - Moves to SHIFT.
- SHIFT:
  - Each cycle presents sreg_a[0]/sreg_b[0], then shifts right with zero fill.
  - Counter counts 0..WIDTH-1.
  - At count WIDTH-1: go to FLUSH if FLUSH_BITS>0; otherwise end the frame.
- FLUSH:
  - Presents 0/0 for FLUSH_BITS cycles.
  - Counter continues from WIDTH to WIDTH+FLUSH_BITS-1, then the frame ends.
- End of frame: go to IDLE, or straight back to SHIFT if a new pair is accepted in the last_bit cycle.
- Counter width: $clog2(WIDTH+FLUSH_BITS+1).
- in_valid while busy and not last_bit: ignored; a_in/b_in are not sampled.
- With FLUSH_BITS>=1 the first flush bit drives the adder with 0+0+carry, so the adder carry is 0 at the start of the next frame.

## Timing
- Outputs out_seq1, out_seq2, bit_valid, first_bit, last_bit and busy are registered.
- in_ready is combinational from state: (state==IDLE) || last_bit.
- Latency: bit k of the operands appears k+1 cycles after the accept edge.
- Frame length: WIDTH+FLUSH_BITS cycles with bit_valid=1.
- Back-to-back: an accept in the last_bit cycle produces first_bit in the next cycle, with no gap.
- Reset values: out_seq1=0, out_seq2=0, bit_valid=0, first_bit=0, last_bit=0, busy=0, state=IDLE, counter=0.
  - in_ready=1 in the first cycle after rst deasserts.
- rst asserted with in_valid: rst wins and nothing is accepted.
- rst mid-frame:
  - The frame is abandoned; all outputs are 0 on the next edge.
  - The downstream adder must be reset together with this block, since its carry is indeterminate.
- a_in/b_in are sampled only at the accept edge; later changes have no effect.

## Structure
- Shared package serial_pkg:
  - state enum ser_state_t {IDLE, SHIFT, FLUSH}.
  - Counter-width helper function, shared with the downstream sum collector.
- Sub-module piso_shift_reg (parameter WIDTH; ports clk, rst, load, shift, d, q_lsb), instantiated twice (A and B).
- FSM and counter live in operand_serializer.

## Test plan
- WIDTH=8, FLUSH_BITS=1; a_in=0x35, b_in=0x5A; single accept.
  - out_seq1 = 1,0,1,0,1,1,0,0,0 and out_seq2 = 0,1,0,1,1,0,1,0,0.
  - first_bit on cycle 1, last_bit on cycle 9.
  - Adder output collected LSB-first = 0x08F.
- a_in=0xFF, b_in=0x01.
  - Adder emits 0,0,0,0,0,0,0,0,1, i.e. 0x100; the flush bit carries out.
  - Adder carry is 0 afterwards.
- Back-to-back frames 0x0F+0x01 then 0x80+0x80, with in_valid held.
  - in_ready pulses only in IDLE/last_bit cycles; 18 contiguous bit_valid cycles.
  - Sums 0x010 and 0x100.
- in_valid with a changing a_in during SHIFT: no effect on the stream; first operand streams intact.
- rst at cycle 4 of a frame: next cycle all outputs 0, busy=0, in_ready=1; a new accept streams from bit 0.
- FLUSH_BITS=0, WIDTH=4; a_in=0x9, b_in=0x3: 4 bit cycles, with last_bit on the MSB cycle.
